// File: rtl/lift_pkg.sv
// Shared definitions for the lifting-step sequencer: pixel/address widths,
// FSM state encoding and the pass/direction selector values.
package lift_pkg;

   localparam int PIX_W  = 9;
   localparam int ADDR_W = 7;

   // Representable pixel range; used when the result is clamped.
   localparam int PIX_MAX = (1 << (PIX_W - 1)) - 1;
   localparam int PIX_MIN = -(1 << (PIX_W - 1));

   // pix_even_odd values
   localparam logic PASS_PREDICT = 1'b1;   // writes odd bank
   localparam logic PASS_UPDATE  = 1'b0;   // writes even bank

   // pix_fwd_inv values
   localparam logic DIR_FWD = 1'b1;
   localparam logic DIR_INV = 1'b0;

   // FSM state encoding
   localparam int STATE_W = 3;
   localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
   localparam logic [STATE_W-1:0] S_RD_L  = 3'd1;
   localparam logic [STATE_W-1:0] S_RD_R  = 3'd2;
   localparam logic [STATE_W-1:0] S_RD_C  = 3'd3;
   localparam logic [STATE_W-1:0] S_CAP_C = 3'd4;
   localparam logic [STATE_W-1:0] S_WR    = 3'd5;
   localparam logic [STATE_W-1:0] S_FIN   = 3'd6;

endpackage

// File: rtl/lift_alu.sv
// Combinational lifting arithmetic for one sample.
//   predict: centre -/+ ((left + right) >>> 1)
//   update : centre +/- ((left + right + 2) >>> 2)
// The first sign is the forward transform, the second the inverse.
// Build option LIFT_SAT_EN: clamp the result to the 9-bit signed range
// instead of wrapping modulo 512.
module lift_alu
   import lift_pkg::*;
(
   input  logic [PIX_W-1:0] left,
   input  logic [PIX_W-1:0] right,
   input  logic [PIX_W-1:0] centre,
   input  logic             fwd_inv,
   input  logic             even_odd,
   output logic [PIX_W-1:0] result
);

   logic signed [PIX_W:0]   sum;      // neighbour sum, one guard bit
   logic signed [PIX_W+1:0] sum_rnd;  // extra bit so +2 rounding never wraps
   logic signed [PIX_W+1:0] delta;
   logic signed [PIX_W+1:0] ctr;
   logic signed [PIX_W+1:0] raw;
   logic                    sub;

   // Neighbour term, sign choice and final add at full precision
   always_comb begin
      sum     = (PIX_W+1)'($signed(left)) + (PIX_W+1)'($signed(right));
      sum_rnd = (PIX_W+2)'(sum) + $signed((PIX_W+2)'(2));
      if (even_odd == PASS_PREDICT) begin
         delta = (PIX_W+2)'(sum >>> 1);
      end else begin
         delta = sum_rnd >>> 2;
      end
      // forward predict and inverse update subtract; the other two add
      sub = ((even_odd == PASS_PREDICT) == (fwd_inv == DIR_FWD));
      ctr = (PIX_W+2)'($signed(centre));
      raw = sub ? (ctr - delta) : (ctr + delta);
   end

`ifdef LIFT_SAT_EN
   // Clamp to the representable pixel range
   always_comb begin
      if (int'(raw) > PIX_MAX) begin
         result = {1'b0, {(PIX_W-1){1'b1}}};
      end else if (int'(raw) < PIX_MIN) begin
         result = {1'b1, {(PIX_W-1){1'b0}}};
      end else begin
         result = raw[PIX_W-1:0];
      end
   end
`else
   // Two's complement wrap: keep the low pixel bits
   always_comb begin
      result = raw[PIX_W-1:0];
   end
`endif

endmodule

// File: rtl/lift_seq.sv
// One in-place lifting pass over an even/odd pair of sample banks.
// Each sample takes five cycles: fetch left neighbour, fetch right
// neighbour, fetch centre, capture centre, write back.  RAM read data
// arrives one cycle after the address, so every fetch is captured in the
// state that follows it.  Edge samples use symmetric extension by clamping
// the neighbour address, so no address outside 0..ROW_HALF-1 is driven.
// Build option LIFT_SAT_EN (see lift_alu) selects saturating results.
module lift_seq
   import lift_pkg::*;
#(
   parameter int ROW_HALF = 64
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              pix_fwd_inv,
   input  logic              pix_even_odd,
   input  logic [PIX_W-1:0]  pix_dout_even,
   input  logic [PIX_W-1:0]  pix_dout_odd,
   output logic [ADDR_W-1:0] pix_addr_even,
   output logic [ADDR_W-1:0] pix_addr_odd,
   output logic [PIX_W-1:0]  pix_din_even,
   output logic [PIX_W-1:0]  pix_din_odd,
   output logic              pix_we_even,
   output logic              pix_we_odd,
   output logic [PIX_W-1:0]  pix_left,
   output logic [PIX_W-1:0]  pix_right,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ROW_HALF - 1);

   logic [STATE_W-1:0] state_q,  state_d;
   logic [ADDR_W-1:0]  i_q,      i_d;
   logic               fwd_q,    fwd_d;
   logic               eo_q,     eo_d;
   logic [ADDR_W-1:0]  addr_e_q, addr_e_d;
   logic [ADDR_W-1:0]  addr_o_q, addr_o_d;
   logic [PIX_W-1:0]   left_q,   left_d;
   logic [PIX_W-1:0]   right_q,  right_d;
   logic [PIX_W-1:0]   centre_q, centre_d;
   logic               busy_q,   busy_d;
   logic               done_q,   done_d;

   logic [PIX_W-1:0]   nb_dout;   // bank holding the neighbours
   logic [PIX_W-1:0]   ctr_dout;  // bank holding the centre (and the result)
   logic [PIX_W-1:0]   result;
   logic               wr_en;

   assign nb_dout  = (eo_q == PASS_PREDICT) ? pix_dout_even : pix_dout_odd;
   assign ctr_dout = (eo_q == PASS_PREDICT) ? pix_dout_odd  : pix_dout_even;

   lift_alu u_alu (
      .left     (left_q),
      .right    (right_q),
      .centre   (centre_q),
      .fwd_inv  (fwd_q),
      .even_odd (eo_q),
      .result   (result)
   );

   // Sequencing, capture and address generation for the next cycle
   always_comb begin
      state_d  = state_q;
      i_d      = i_q;
      fwd_d    = fwd_q;
      eo_d     = eo_q;
      addr_e_d = addr_e_q;
      addr_o_d = addr_o_q;
      left_d   = left_q;
      right_d  = right_q;
      centre_d = centre_q;
      done_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RD_L;
               i_d     = '0;
               fwd_d   = pix_fwd_inv;
               eo_d    = pix_even_odd;
            end
         end
         S_RD_L:  state_d = S_RD_R;
         S_RD_R: begin
            left_d  = nb_dout;
            state_d = S_RD_C;
         end
         S_RD_C: begin
            right_d = nb_dout;
            state_d = S_CAP_C;
         end
         S_CAP_C: begin
            centre_d = ctr_dout;
            state_d  = S_WR;
         end
         S_WR: begin
            if (i_q != LAST_IDX) begin
               i_d     = i_q + 7'd1;
               state_d = S_RD_L;
            end else begin
               state_d = S_FIN;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      // The address register for a read state is loaded on entry, so it
      // is present on the RAM pins for the whole state.  The centre address
      // is held through CAP_C and WR and doubles as the write address.
      case (state_d)
         S_RD_L: begin
            if (eo_d == PASS_PREDICT) addr_e_d = i_d;
            else                      addr_o_d = (i_d == '0) ? '0 : i_d - 7'd1;
         end
         S_RD_R: begin
            if (eo_d == PASS_PREDICT) addr_e_d = (i_d == LAST_IDX) ? i_d : i_d + 7'd1;
            else                      addr_o_d = i_d;
         end
         S_RD_C: begin
            if (eo_d == PASS_PREDICT) addr_o_d = i_d;
            else                      addr_e_d = i_d;
         end
         default: ;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and datapath registers, synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         i_q      <= '0;
         fwd_q    <= 1'b0;
         eo_q     <= 1'b0;
         addr_e_q <= '0;
         addr_o_q <= '0;
         left_q   <= '0;
         right_q  <= '0;
         centre_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         i_q      <= i_d;
         fwd_q    <= fwd_d;
         eo_q     <= eo_d;
         addr_e_q <= addr_e_d;
         addr_o_q <= addr_o_d;
         left_q   <= left_d;
         right_q  <= right_d;
         centre_q <= centre_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // Write strobe is masked by rst so a reset landing in WR aborts that
   // sample's write instead of letting it complete on the reset edge.
   assign wr_en        = (state_q == S_WR) && !rst;
   assign pix_we_odd   = wr_en && (eo_q == PASS_PREDICT);
   assign pix_we_even  = wr_en && (eo_q == PASS_UPDATE);
   assign pix_din_odd  = pix_we_odd  ? result : '0;
   assign pix_din_even = pix_we_even ? result : '0;

   assign pix_addr_even = addr_e_q;
   assign pix_addr_odd  = addr_o_q;
   assign pix_left      = left_q;
   assign pix_right     = right_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: tb/tb_lift_seq.sv
// Bench for lift_seq with ROW_HALF = 4: directed passes plus random passes
// checked against an array-level model of the lifting rules.
module tb_lift_seq;

   localparam int N = 4;

   logic              clk = 1'b0;
   logic              rst, start, fwd, eo;
   logic signed [8:0] dout_e, dout_o, din_e, din_o, pl, pr;
   logic [6:0]        addr_e, addr_o;
   logic              we_e, we_o, busy, done;

   lift_seq #(.ROW_HALF(N)) dut (
      .clk(clk), .rst(rst), .start(start),
      .pix_fwd_inv(fwd), .pix_even_odd(eo),
      .pix_dout_even(dout_e), .pix_dout_odd(dout_o),
      .pix_addr_even(addr_e), .pix_addr_odd(addr_o),
      .pix_din_even(din_e), .pix_din_odd(din_o),
      .pix_we_even(we_e), .pix_we_odd(we_o),
      .pix_left(pl), .pix_right(pr),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Bank RAMs, one-cycle read latency; bulk load only while idle
   logic signed [8:0] ram_e [N];
   logic signed [8:0] ram_o [N];
   logic signed [8:0] ld_e  [N];
   logic signed [8:0] ld_o  [N];
   logic              ld = 1'b0;

   always @(posedge clk) begin
      dout_e <= (addr_e < 7'(N)) ? ram_e[addr_e[1:0]] : 9'sd0;
      dout_o <= (addr_o < 7'(N)) ? ram_o[addr_o[1:0]] : 9'sd0;
      if (ld) begin
         for (int k = 0; k < N; k++) begin
            ram_e[k] <= ld_e[k];
            ram_o[k] <= ld_o[k];
         end
      end else begin
         if (we_e && addr_e < 7'(N)) ram_e[addr_e[1:0]] <= din_e;
         if (we_o && addr_o < 7'(N)) ram_o[addr_o[1:0]] <= din_o;
      end
   end

   // Bus monitor: write/done counts, address range, exclusive strobes
   int n_wr_e = 0, n_wr_o = 0, n_done = 0, n_addr_bad = 0, n_both = 0;
   always @(negedge clk) begin
      if (we_e) n_wr_e++;
      if (we_o) n_wr_o++;
      if (done) n_done++;
      if (addr_e >= 7'(N) || addr_o >= 7'(N)) n_addr_bad++;
      if (we_e && we_o) n_both++;
   end

   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference model: whole-bank lifting on integers
   int m_e [N];
   int m_o [N];

   function automatic int fix9(input int v);
`ifdef LIFT_SAT_EN
      if (v > 255) return 255;
      if (v < -256) return -256;
      return v;
`else
      int w;
      w = v & 511;
      return (w >= 256) ? w - 512 : w;
`endif
   endfunction

   task automatic model_pass(input bit f, input bit predict);
      int l, r, t;
      for (int k = 0; k < N; k++) begin
         if (predict) begin
            l = m_e[k];
            r = m_e[(k == N-1) ? N-1 : k+1];
            t = (l + r) >>> 1;
            m_o[k] = fix9(f ? m_o[k] - t : m_o[k] + t);
         end else begin
            l = m_o[(k == 0) ? 0 : k-1];
            r = m_o[k];
            t = (l + r + 2) >>> 2;
            m_e[k] = fix9(f ? m_e[k] + t : m_e[k] - t);
         end
      end
   endtask

   task automatic load_from_model();
      for (int k = 0; k < N; k++) begin
         ld_e[k] = 9'(m_e[k]);
         ld_o[k] = 9'(m_o[k]);
      end
      @(negedge clk); ld = 1'b1;
      @(negedge clk); ld = 1'b0;
   endtask

   task automatic check_banks(input string tag);
      for (int k = 0; k < N; k++) begin
         chk($sformatf("%s even[%0d]", tag, k), int'(ram_e[k]), m_e[k]);
         chk($sformatf("%s odd[%0d]",  tag, k), int'(ram_o[k]), m_o[k]);
      end
   endtask

   // Start pulse, then mode inputs flipped for the rest of the pass.
   // lat counts cycles after the start cycle until done is seen.
   task automatic run_pass(input bit f, input bit e, input bit restart, output int lat);
      @(negedge clk); start = 1'b1; fwd = f; eo = e;
      @(negedge clk); start = 1'b0; fwd = ~f; eo = ~e; lat = 1;
      chk("busy_after_start", int'(busy), 1);
      while (done !== 1'b1 && lat < 400) begin
         start = (restart && lat == 7) ? 1'b1 : 1'b0;
         @(negedge clk); lat++;
      end
      start = 1'b0;
      chk("busy_at_done", int'(busy), 0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int lat, cnt, d0, we0, wo0, exp0;
      int exp_p [N] = '{-10, -20, -30, -35};
      int exp_u [N] = '{5, 13, 18, 24};
      int org_e [N] = '{10, 20, 30, 40};
      int org_o [N] = '{5, 5, 5, 5};
      bit rf, re;

      rst = 1'b1; start = 1'b0; fwd = 1'b0; eo = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst busy", int'(busy), 0);
      chk("rst done", int'(done), 0);
      chk("rst we_e", int'(we_e), 0);
      chk("rst we_o", int'(we_o), 0);
      chk("rst addr_e", int'(addr_e), 0);
      chk("rst addr_o", int'(addr_o), 0);
      chk("rst din_e", int'(din_e), 0);
      chk("rst din_o", int'(din_o), 0);
      chk("rst left", int'(pl), 0);
      chk("rst right", int'(pr), 0);
      rst = 1'b0;

      // Directed predict forward
      m_e = org_e; m_o = org_o;
      load_from_model();
      model_pass(1'b1, 1'b1);
      run_pass(1'b1, 1'b1, 1'b0, lat);
      chk("pf latency", lat, 5*N + 2);
      for (int k = 0; k < N; k++) chk($sformatf("pf const odd[%0d]", k), int'(ram_o[k]), exp_p[k]);
      check_banks("pf");

      // Update forward on the predicted data
      model_pass(1'b1, 1'b0);
      run_pass(1'b1, 1'b0, 1'b0, lat);
      chk("uf latency", lat, 5*N + 2);
      for (int k = 0; k < N; k++) chk($sformatf("uf const even[%0d]", k), int'(ram_e[k]), exp_u[k]);
      check_banks("uf");

      // Inverse update then inverse predict restores the originals
      model_pass(1'b0, 1'b0);
      run_pass(1'b0, 1'b0, 1'b0, lat);
      check_banks("ui");
      model_pass(1'b0, 1'b1);
      run_pass(1'b0, 1'b1, 1'b0, lat);
      for (int k = 0; k < N; k++) begin
         chk($sformatf("round even[%0d]", k), int'(ram_e[k]), org_e[k]);
         chk($sformatf("round odd[%0d]",  k), int'(ram_o[k]), org_o[k]);
      end

      // Overflow corner: -256 - 100
      m_e = '{100, 100, 100, 100}; m_o = '{-256, 7, -3, 50};
      load_from_model();
      model_pass(1'b1, 1'b1);
      run_pass(1'b1, 1'b1, 1'b0, lat);
`ifdef LIFT_SAT_EN
      exp0 = -256;
`else
      exp0 = 156;
`endif
      chk("ovf odd[0]", int'(ram_o[0]), exp0);
      check_banks("ovf");

      // Random passes
      for (int t = 0; t < 8; t++) begin
         for (int k = 0; k < N; k++) begin
            m_e[k] = int'($urandom_range(511)) - 256;
            m_o[k] = int'($urandom_range(511)) - 256;
         end
         rf = 1'($urandom_range(1));
         re = 1'($urandom_range(1));
         load_from_model();
         model_pass(rf, re);
         run_pass(rf, re, 1'b0, lat);
         chk($sformatf("rnd%0d latency", t), lat, 5*N + 2);
         check_banks($sformatf("rnd%0d", t));
      end

      // Second start while busy is ignored
      for (int k = 0; k < N; k++) begin
         m_e[k] = int'($urandom_range(511)) - 256;
         m_o[k] = int'($urandom_range(511)) - 256;
      end
      load_from_model();
      d0 = n_done; we0 = n_wr_e; wo0 = n_wr_o;
      model_pass(1'b1, 1'b0);
      run_pass(1'b1, 1'b0, 1'b1, lat);
      repeat (30) @(negedge clk);
      chk("restart latency", lat, 5*N + 2);
      chk("restart dones", n_done - d0, 1);
      chk("restart even writes", n_wr_e - we0, N);
      chk("restart odd writes", n_wr_o - wo0, 0);
      check_banks("restart");

      // Reset during the write of sample 2 of a predict pass
      m_e = org_e; m_o = org_o;
      load_from_model();
      @(negedge clk); start = 1'b1; fwd = 1'b1; eo = 1'b1;
      @(negedge clk); start = 1'b0;
      cnt = 0;
      for (int c = 0; c < 100 && cnt < 3; c++) begin
         if (we_o) cnt++;
         if (cnt == 3) rst = 1'b1;
         else @(negedge clk);
      end
      chk("rst reached WR2", cnt, 3);
      @(negedge clk);
      chk("midrst busy", int'(busy), 0);
      chk("midrst we_o", int'(we_o), 0);
      chk("midrst we_e", int'(we_e), 0);
      chk("midrst done", int'(done), 0);
      chk("midrst addr_o", int'(addr_o), 0);
      chk("midrst left", int'(pl), 0);
      rst = 1'b0;
      d0 = n_done; we0 = n_wr_e; wo0 = n_wr_o;
      repeat (10) @(negedge clk);
      chk("post-rst writes", (n_wr_e - we0) + (n_wr_o - wo0), 0);
      chk("post-rst dones", n_done - d0, 0);
      chk("midrst odd[0]", int'(ram_o[0]), -10);
      chk("midrst odd[1]", int'(ram_o[1]), -20);
      chk("midrst odd[2]", int'(ram_o[2]), 5);
      chk("midrst odd[3]", int'(ram_o[3]), 5);

      chk("address range", n_addr_bad, 0);
      chk("both we", n_both, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
